// File: rtl/sprite_blitter.sv
// sprite_blitter: copies a square sprite from a synchronous ROM into the frame buffer write port,
// skipping transparent pixels and clipping off-screen ones; define SPRITE_BLITTER_FLIP_EN for horizontal mirroring.
module sprite_blitter #(
  parameter int ADDR_WIDTH  = 10,
  parameter int DATA_WIDTH  = 8,
  parameter int FB_W_LOG2   = 5,
  parameter int SPR_LOG2    = 2,
  parameter int ID_WIDTH    = 3,
  parameter int TRANSPARENT = 0
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  input  logic [FB_W_LOG2-1:0]                pos_x,
  input  logic [ADDR_WIDTH-FB_W_LOG2-1:0]     pos_y,
  input  logic [ID_WIDTH-1:0]                 spr_id,
  input  logic                                flip_x,
  output logic                                ready,
  output logic                                done,
  output logic [ID_WIDTH+2*SPR_LOG2-1:0]      spr_addr,
  input  logic [DATA_WIDTH-1:0]               spr_data,
  output logic                                we,
  output logic [ADDR_WIDTH-1:0]               addr_w,
  output logic [DATA_WIDTH-1:0]               din
);
  localparam int H  = ADDR_WIDTH - FB_W_LOG2;
  localparam int K  = 2 * SPR_LOG2;
  localparam int SA = ID_WIDTH + K;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t                 r_state, w_next;
  logic [FB_W_LOG2-1:0]   r_px;
  logic [H-1:0]           r_py;
  logic [ID_WIDTH-1:0]    r_id;
  logic [K-1:0]           r_k;
  logic                   r_dc;
  logic [SA-1:0]          r_spr_hold;
  logic                   r_v1;
  logic [FB_W_LOG2:0]     r_sx1;
  logic [H:0]             r_sy1;
  logic                   r_we;
  logic [ADDR_WIDTH-1:0]  r_addr_w;
  logic [DATA_WIDTH-1:0]  r_din;
  logic [SPR_LOG2-1:0]    w_dx, w_dy, w_dx_eff;
  logic [SA-1:0]          w_spr_addr;
  logic                   w_accept;
  assign w_accept   = r_state == IDLE && start;
  assign w_dx       = r_k[SPR_LOG2-1:0];
  assign w_dy       = r_k[K-1:SPR_LOG2];
`ifdef SPRITE_BLITTER_FLIP_EN
  logic r_flip;
  always_ff @(posedge clk)
    if (reset) r_flip <= 1'b0;
    else if (w_accept) r_flip <= flip_x;
  assign w_dx_eff = r_flip ? ~w_dx : w_dx;
`else
  logic w_unused_flip;
  assign w_unused_flip = flip_x;
  assign w_dx_eff      = w_dx;
`endif
  assign w_spr_addr = {r_id, w_dy, w_dx_eff};
  assign spr_addr   = r_state == RUN ? w_spr_addr : r_spr_hold;
  assign ready      = r_state == IDLE;
  assign done       = r_state == DRAIN && r_dc;
  assign we         = r_we;
  assign addr_w     = r_addr_w;
  assign din        = r_din;
  always_comb begin
    w_next = r_state;
    w_next = r_state == IDLE ? (start ? RUN : IDLE)
           : r_state == RUN  ? (&r_k ? DRAIN : RUN)
           : (r_dc ? IDLE : DRAIN);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_px       <= '0;
      r_py       <= '0;
      r_id       <= '0;
      r_k        <= '0;
      r_dc       <= 1'b0;
      r_spr_hold <= '0;
      r_v1       <= 1'b0;
      r_sx1      <= '0;
      r_sy1      <= '0;
      r_we       <= 1'b0;
      r_addr_w   <= '0;
      r_din      <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_px <= pos_x;
        r_py <= pos_y;
        r_id <= spr_id;
        r_k  <= '0;
      end
      if (r_state == RUN) begin
        r_k        <= r_k + 1'b1;
        r_spr_hold <= w_spr_addr;
      end
      r_dc  <= r_state == DRAIN && !r_dc;
      r_v1  <= r_state == RUN;
      // one extra bit so clipped pixels are detected instead of wrapping to column/row 0
      r_sx1 <= {1'b0, r_px} + (FB_W_LOG2+1)'(w_dx);
      r_sy1 <= {1'b0, r_py} + (H+1)'(w_dy);
      r_we  <= r_v1 && spr_data != DATA_WIDTH'(TRANSPARENT) && !r_sx1[FB_W_LOG2] && !r_sy1[H];
      if (r_v1) begin
        r_addr_w <= {r_sy1[H-1:0], r_sx1[FB_W_LOG2-1:0]};
        r_din    <= spr_data;
      end
    end
  end
endmodule

// File: tb/tb_sprite_blitter.sv
// tb_sprite_blitter: scoreboard bench; stimulus queues expected writes/done pulses, a negedge monitor checks them.
module tb_sprite_blitter;
  logic       clk = 1'b0, reset = 1'b1, start = 1'b0, flip_x = 1'b0;
  logic [4:0] pos_x = '0, pos_y = '0;
  logic [2:0] spr_id = '0;
  logic       ready, done, we;
  logic [6:0] spr_addr;
  logic [7:0] spr_data, din;
  logic [9:0] addr_w;
`ifdef SPRITE_BLITTER_FLIP_EN
  localparam bit FLIP = 1'b1;
`else
  localparam bit FLIP = 1'b0;
`endif
  always #5 clk = ~clk;
  sprite_blitter dut (
    .clk(clk), .reset(reset), .start(start), .pos_x(pos_x), .pos_y(pos_y),
    .spr_id(spr_id), .flip_x(flip_x), .ready(ready), .done(done),
    .spr_addr(spr_addr), .spr_data(spr_data), .we(we), .addr_w(addr_w), .din(din)
  );
  logic [7:0] rom [128];
  always @(posedge clk) spr_data <= rom[spr_addr];
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct {int c; int a; int d;} wr_t;
  wr_t wq[$];
  int  dq[$];
  wr_t e;
  int  de;
  int  n_cmp = 0, n_bad = 0;
  bit  mon_en = 1'b0;
  task automatic chk(string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  always @(negedge clk) if (mon_en) begin
    if (we) begin
      if (wq.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_write: addr %0d data %0d expected none (cycle %0d)", addr_w, din, cyc);
      end else begin
        e = wq.pop_front();
        chk("wr_cycle", cyc, e.c);
        chk("wr_addr", addr_w, e.a);
        chk("wr_data", din, e.d);
      end
    end
    if (done) begin
      if (dq.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_done: got pulse expected none (cycle %0d)", cyc);
      end else begin
        de = dq.pop_front();
        chk("done_cycle", cyc, de);
      end
    end
  end
  task automatic push_exp(int id, int x, int y, bit fl, int c0, int last);
    for (int k = 0; k < 16; k++) begin
      int dx = k % 4, dy = k / 4, ex, sx, sy;
      logic [7:0] p;
      ex = (fl && FLIP) ? 3 - dx : dx;
      p  = rom[id*16 + dy*4 + ex];
      sx = x + dx;
      sy = y + dy;
      if (p != 0 && sx < 32 && sy < 32 && c0 + 3 + k <= last)
        wq.push_back('{c0 + 3 + k, sy*32 + sx, int'(p)});
    end
  endtask
  task automatic blit(int id, int x, int y, bit fl, bit hold);
    int c0 = cyc;
    int t  = 0;
    chk("ready_at_start", ready, 1);
    spr_id = 3'(id); pos_x = 5'(x); pos_y = 5'(y); flip_x = fl; start = 1'b1;
    push_exp(id, x, y, fl, c0, c0 + 18);
    dq.push_back(c0 + 18);
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    pos_x = ~pos_x; pos_y = ~pos_y; spr_id = ~spr_id; flip_x = ~flip_x;
    chk("ready_busy", ready, 0);
    if (hold) begin
      repeat (8) begin @(posedge clk); #1; end
      start = 1'b0;
    end
    while (!ready && t < 40) begin @(posedge clk); #1; t++; end
    chk("ready_cycle", cyc, c0 + 19);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end
  initial begin
    int c0;
    for (int i = 0; i < 128; i++) rom[i] = 8'h00;
    for (int k = 0; k < 16; k++) begin
      rom[16 + k] = 8'h3C;
      rom[32 + k] = (((k % 4) + (k / 4)) % 2 == 1) ? 8'(8'h40 + k) : 8'h00;
      rom[48 + k] = 8'h77;
    end
    for (int k = 0; k < 4; k++) rom[64 + k] = 8'(k + 1);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", ready, 1);
    chk("rst_done", done, 0);
    chk("rst_we", we, 0);
    chk("rst_addr_w", addr_w, 0);
    chk("rst_din", din, 0);
    chk("rst_spr_addr", spr_addr, 0);
    reset = 1'b0;
    mon_en = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      chk("idle_ready", ready, 1);
      chk("idle_we", we, 0);
      chk("idle_done", done, 0);
    end
    blit(1, 4, 2, 1'b0, 1'b0);
    chk("spr_addr_hold", spr_addr, 31);
    blit(2, 10, 5, 1'b0, 1'b0);
    blit(3, 30, 30, 1'b0, 1'b1);
    blit(4, 0, 0, 1'b1, 1'b0);
    blit(4, 0, 0, 1'b0, 1'b0);
    c0 = cyc;
    spr_id = 3'd1; pos_x = 5'd4; pos_y = 5'd2; flip_x = 1'b0; start = 1'b1;
    push_exp(1, 4, 2, 1'b0, c0, c0 + 8);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_cycle", cyc, c0 + 9);
    chk("abort_we", we, 0);
    chk("abort_done", done, 0);
    chk("abort_ready", ready, 1);
    repeat (25) begin @(posedge clk); #1; end
    chk("abort_idle_ready", ready, 1);
    blit(2, 0, 0, 1'b0, 1'b0);
    repeat (5) begin @(posedge clk); #1; end
    chk("wr_queue_empty", wq.size(), 0);
    chk("done_queue_empty", dq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sprite_blitter.md
# sprite_blitter

Upstream writer for the frame buffer RAM. On a start request, copies one square sprite from an external synchronous sprite ROM into the frame buffer at a given (x, y) cell position. Transparent pixels are skipped and off-screen pixels are clipped. Drives the RAM's write port (`we`, `addr_w`, `din`); the video scanner keeps the independent read port.

## Interface
- `ADDR_WIDTH`, 10: frame buffer address bits; buffer holds 2**ADDR_WIDTH cells.
- `DATA_WIDTH`, 8: pixel/colour bits.
- `FB_W_LOG2`, 5: log2 of frame buffer width in cells; height = 2**(ADDR_WIDTH-FB_W_LOG2).
- `SPR_LOG2`, 2: log2 of sprite edge length (default 4x4 sprites).
- `ID_WIDTH`, 3: sprite index bits.
- `TRANSPARENT`, 0: colour value that is never written.

Ports:
- `clk` in 1: single clock, all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: request; accepted only when `ready`=1.
- `pos_x` in FB_W_LOG2: left column of the sprite.
- `pos_y` in ADDR_WIDTH-FB_W_LOG2: top row of the sprite.
- `spr_id` in ID_WIDTH: sprite to draw.
- `flip_x` in 1: horizontal mirror request (see Configuration).
- `ready` out 1: idle, start may be accepted.
- `done` out 1: one-cycle pulse at the end of a blit.
- `spr_addr` out ID_WIDTH+2*SPR_LOG2: ROM address {id, dy, dx}.
- `spr_data` in DATA_WIDTH: ROM data, valid one cycle after `spr_addr`.
- `we` out 1: frame buffer write enable.
- `addr_w` out ADDR_WIDTH: write address {y, x}.
- `din` out DATA_WIDTH: write data.

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE: `ready`=1. On `start`=1, latch pos_x, pos_y, spr_id and flip_x, clear dx/dy, then go to RUN. Inputs are ignored at all other times.
- RUN: each cycle, issue `spr_addr`={id, dy, dx_eff}, where dx_eff = flip ? (2**SPR_LOG2-1-dx) : dx. Advance dx; when dx wraps, increment dy. After issuing pixel N-1 (N=2**(2*SPR_LOG2)), go to DRAIN.
- Pipeline stage 1 (the ROM) returns `spr_data`. Stage 2 registers the write outputs:
  - `we` = (spr_data != TRANSPARENT) && onscreen.
  - `addr_w` = {pos_y+dy, pos_x+dx}.
  - `din` = spr_data.
- onscreen is computed with one-bit-wider sums: false if pos_x+dx >= 2**FB_W_LOG2 or pos_y+dy >= FB height. Clipped pixels never wrap to column 0 or row 0.
- `addr_w` uses the unflipped screen dx. Only the ROM address is mirrored.
- DRAIN: wait 2 cycles for the pipeline to empty. `done` pulses in the cycle carrying the final write slot, then return to IDLE.
- `spr_addr` holds its last value when not in RUN. `we`=0 whenever no valid pixel occupies stage 2.

## Timing
- Reset values (cycle after `reset` is sampled high):
  - state = IDLE, `ready`=1, `done`=0, `we`=0.
  - `addr_w`=0, `din`=0, `spr_addr`=0.
- Start accepted in cycle 0. `ready`=0 from cycle 1.
- `spr_addr` for pixel k is issued in cycle 1+k; `spr_data` for it is valid in cycle 2+k; its write slot is in cycle 3+k.
- Last write slot is cycle N+2, with `done`=1 in that cycle. `ready`=1 in cycle N+3; a new start may be accepted in that cycle.
- Default N=16: 19 cycles start-to-ready, back-to-back throughput one blit per 19 cycles.
- Reset mid-blit: aborts immediately. `we`=0 from the next cycle, no `done` pulse, and pipelined pixels are discarded.
- `start` held high while busy: ignored; no queuing.

## Configuration
- `SPRITE_BLITTER_FLIP_EN` defined: `flip_x` is latched at start and mirrors sprite columns as above.
- Not defined: the `flip_x` port remains but is ignored, dx_eff = dx, and the mirror logic is absent.

## Test plan
- Reset, then idle: `ready`=1, `we`=0, `done`=0 for 10 cycles with `start`=0.
- Sprite 1 with all pixels 8'h3C at (4,2) -> 16 writes in cycles 3..18. First `addr_w`=2*32+4=68, last =5*32+7=167; `done` in cycle 18; `ready` in cycle 19.
- Sprite with TRANSPARENT checkerboard -> exactly 8 writes, at the non-zero cells only.
- pos_x=30, pos_y=30 -> only 4 writes, at addresses 990, 991, 1022, 1023; no address below 960 is written.
- With FLIP_EN, flip_x=1 and row 0 = {1,2,3,4} at (0,0) -> addresses 0..3 receive 4,3,2,1. Without FLIP_EN -> 1,2,3,4.
- `reset` pulsed in cycle 8 of a blit -> `we`=0 from cycle 9, no `done`, `ready`=1. A subsequent start completes normally.
